uart_rx: RTL and testbench

Serial receiver for the 11-bit UART frame produced by the existing transmitter: start bit (0), 8 data bits LSB first, even-parity bit, stop bit (1). The parity bit is the XOR of the 8 data bits. Default timing is 9600 bps at 5210 clocks per bit. The block sits between the board RX pin and user logic. It synchronizes the line, detects and qualifies the start bit, samples each bit at mid-bit, and presents the byte with a one-cycle valid strobe and error flags. Looped back to the transmitter, it closes the link.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Received-byte bus from uart_rx to user logic: data, one-cycle valid strobe
// and the per-frame error flags that qualify it.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;

  modport master (output rx_data, output rx_valid, output parity_err, output frame_err);
  modport slave  (input  rx_data, input  rx_valid, input  parity_err, input  frame_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver for start + 8 data (LSB first) + even parity + stop frames.
// Mid-bit sampling from a synchronized line; byte presented with a one-cycle strobe.
module uart_rx #(
  parameter int BIT_COUNTS  = 5210,
  parameter int HALF_COUNTS = 2605
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  uart_rx_if.master  rx_bus,
  output logic       busy,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2(BIT_COUNTS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             par_err_r;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             parity_err_r;
  logic             frame_err_r;
  logic             busy_r;
  logic             fall_s;
  logic [CNT_W-1:0] last_s;
  logic             tick_s;

  // Two-flop line synchronizer plus previous sample for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Falling-edge detect and the baud-counter sample instant for the current state.
  always_comb begin
    fall_s = prev_r & ~sync2_r;
    if (state_r == ST_START) begin
      last_s = CNT_W'(HALF_COUNTS - 1);
    end else begin
      last_s = CNT_W'(BIT_COUNTS - 1);
    end
    tick_s = (cnt_r == last_s);
  end

  // Receive FSM; outputs are loaded on the STOP->DONE edge so they are visible during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      bit_cnt_r    <= 4'd0;
      shift_r      <= 8'h00;
      par_err_r    <= 1'b0;
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r     <= {CNT_W{1'b0}};
          bit_cnt_r <= 4'd0;
          if (fall_s) begin
            state_r <= ST_START;
            busy_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
            if (sync2_r) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {sync2_r, shift_r[7:1]};
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_r <= 4'd0;
              state_r   <= ST_PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (tick_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            par_err_r <= sync2_r ^ even_parity(shift_r);
            state_r   <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            cnt_r        <= {CNT_W{1'b0}};
            rx_data_r    <= shift_r;
            rx_valid_r   <= 1'b1;
            parity_err_r <= par_err_r;
            frame_err_r  <= ~sync2_r;
            busy_r       <= 1'b0;
            state_r      <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= ST_IDLE;
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_bus.rx_data    = rx_data_r;
  assign rx_bus.rx_valid   = rx_valid_r;
  assign rx_bus.parity_err = parity_err_r;
  assign rx_bus.frame_err  = frame_err_r;
  assign busy              = busy_r;
  assign state             = state_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit: framing, errors, glitch, back-to-back
// frames and mid-frame reset, with hand-computed expectations.
module tb_uart_rx;
  localparam int BIT  = 16;
  localparam int HALF = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       rx_in = 1'b1;
  logic       busy;
  logic [2:0] state;

  uart_rx_if bus ();

  uart_rx #(.BIT_COUNTS(BIT), .HALF_COUNTS(HALF)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .rx_bus(bus),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int strobes = 0;
  int last_valid_cyc = 0;
  int busy_cycles = 0;
  int start_cyc = 0;
  logic [9:0] cap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe/busy monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rst && bus.rx_valid) begin
      strobes++;
      last_valid_cyc = cyc;
      cap_q.push_back({bus.frame_err, bus.parity_err, bus.rx_data});
    end
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    idle(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(d[k]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic get_cap(output logic [9:0] v);
    if (cap_q.size() > 0) v = cap_q.pop_front();
    else v = 10'bx;
  endtask

  logic [9:0] cap;
  int s0;

  initial begin
    // Reset state
    idle(3);
    check("rst_data", bus.rx_data, 32'h00);
    check("rst_valid", bus.rx_valid, 32'd0);
    check("rst_perr", bus.parity_err, 32'd0);
    check("rst_ferr", bus.frame_err, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_state", state, 32'd0);
    rst = 1'b1;
    idle(5);

    // Clean frame 0xA5 with exact strobe timing
    s0 = strobes;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    check("a5_strobes", strobes - s0, 32'd1);
    check("a5_time", last_valid_cyc, start_cyc + 171);
    get_cap(cap);
    check("a5_cap", cap, {2'b00, 8'hA5});
    check("a5_hold", bus.rx_data, 32'hA5);
    check("a5_valid_low", bus.rx_valid, 32'd0);
    check("a5_busy", busy, 32'd0);

    // Bad parity then good parity
    send_frame(8'h01, 1'b0, 1'b1);
    idle(4);
    get_cap(cap);
    check("p01_cap", cap, {2'b01, 8'h01});
    check("p01_perr_hold", bus.parity_err, 32'd1);
    send_frame(8'h02, 1'b1, 1'b1);
    idle(4);
    get_cap(cap);
    check("p02_cap", cap, {2'b00, 8'h02});

    // Stop bit 0, then line held low (break)
    s0 = strobes;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(100);
    check("brk_strobes", strobes - s0, 32'd1);
    get_cap(cap);
    check("brk_cap", cap, {2'b10, 8'h3C});
    check("brk_state", state, 32'd0);
    rx_in = 1'b1;
    idle(40);
    check("brk_after", strobes - s0, 32'd1);

    // Short low glitch
    s0 = strobes;
    busy_cycles = 0;
    rx_in = 1'b0;
    idle(HALF - 3);
    rx_in = 1'b1;
    idle(40);
    check("gl_strobes", strobes - s0, 32'd0);
    check("gl_busy_cycles", busy_cycles, 32'd8);
    check("gl_state", state, 32'd0);
    check("gl_data_hold", bus.rx_data, 32'h3C);
    check("gl_ferr_hold", bus.frame_err, 32'd1);

    // Back-to-back frames
    s0 = strobes;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(4);
    check("b2b_strobes", strobes - s0, 32'd3);
    get_cap(cap);
    check("b2b_0", cap, {2'b00, 8'h00});
    get_cap(cap);
    check("b2b_1", cap, {2'b00, 8'hFF});
    get_cap(cap);
    check("b2b_2", cap, {2'b00, 8'h55});

    // Reset mid-data of 0x5A, then 0xC3
    s0 = strobes;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_busy", busy, 32'd1);
    rst = 1'b0;
    rx_in = 1'b1;
    idle(2);
    check("mr_data", bus.rx_data, 32'h00);
    check("mr_busy", busy, 32'd0);
    check("mr_state", state, 32'd0);
    check("mr_valid", bus.rx_valid, 32'd0);
    rst = 1'b1;
    idle(100);
    check("mr_nostrobe", strobes - s0, 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(4);
    check("c3_strobes", strobes - s0, 32'd1);
    get_cap(cap);
    check("c3_cap", cap, {2'b00, 8'hC3});
    check("c3_time", last_valid_cyc, start_cyc + 171);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
